// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Measures an incoming PWM waveform. Once per PWM period it reports the high
// time and the rising-to-rising period, both in MClk cycles.
//
// Parameters:
//   BIT_WIDTH   - width of the cycle counter and of HighCount/PeriodCount
//   SYNC_STAGES - synchronizer depth on PwmIn (2 or more)
//   FILT_LEN    - consecutive stable samples the glitch filter requires
//                 (only used when PWM_CAPTURE_GLITCH_FILTER_EN is defined)
//
// Optional feature macro: PWM_CAPTURE_GLITCH_FILTER_EN
//   When defined, a run-length glitch filter sits between the synchronizer
//   and the edge detector. Every edge is then delayed by FILT_LEN cycles.
//
// Ports:
//   MClk        in   system clock, rising edge
//   Rst         in   asynchronous active-high reset, clears every flop
//   En          in   capture enable (0 forces IDLE; results are held)
//   PwmIn       in   asynchronous PWM input
//   HighCount   out  high time of the last complete period
//   PeriodCount out  rising-to-rising period of the last complete period
//   Valid       out  one-cycle pulse when HighCount/PeriodCount update
//   Stuck       out  no edge for 2^BIT_WIDTH-1 cycles
//   StuckLevel  out  synchronized level captured when Stuck was raised
//   Overflow    out  sticky: a counter saturation has occurred
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int BIT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                 MClk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic                 PwmIn,
  output logic [BIT_WIDTH-1:0] HighCount,
  output logic [BIT_WIDTH-1:0] PeriodCount,
  output logic                 Valid,
  output logic                 Stuck,
  output logic                 StuckLevel,
  output logic                 Overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [BIT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [BIT_WIDTH-1:0] CNT_ONE = BIT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   w_lvl;
  logic                   r_lvl_d;
  logic                   w_rise;
  logic                   w_fall;

  state_t                 r_state;
  logic [BIT_WIDTH-1:0]   r_cnt;
  logic [BIT_WIDTH-1:0]   r_hi_lat;
  logic [BIT_WIDTH-1:0]   r_high_count;
  logic [BIT_WIDTH-1:0]   r_period_count;
  logic                   r_valid;
  logic                   r_stuck;
  logic                   r_stuck_level;
  logic                   r_overflow;

  // Synchronizer: new samples enter at bit 0, the settled level leaves at the top.
  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], PwmIn};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic             r_filt;
  logic [RUN_W-1:0] r_run;

  // The filtered level follows s only once s has disagreed with it for
  // FILT_LEN consecutive samples; any shorter excursion restarts the run.
  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      r_filt <= 1'b0;
      r_run  <= '0;
    end else if (w_s != r_filt) begin
      if (r_run == RUN_W'(FILT_LEN - 1)) begin
        r_filt <= w_s;
        r_run  <= '0;
      end else begin
        r_run <= r_run + RUN_W'(1);
      end
    end else begin
      r_run <= '0;
    end
  end

  assign w_lvl = r_filt;
`else
  logic w_unused_filt_len;

  assign w_unused_filt_len = (FILT_LEN > 0);
  assign w_lvl             = w_s;
`endif

  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      r_lvl_d <= 1'b0;
    end else begin
      r_lvl_d <= w_lvl;
    end
  end

  assign w_rise = w_lvl & ~r_lvl_d;
  assign w_fall = ~w_lvl & r_lvl_d;

  // Measurement FSM. The counter is 1 on the cycle after a rise, so at the
  // closing edge it holds exactly the number of cycles since the opening one.
  // Saturation is tested before edges so the counter can never wrap.
  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_hi_lat       <= '0;
      r_high_count   <= '0;
      r_period_count <= '0;
      r_valid        <= 1'b0;
      r_stuck        <= 1'b0;
      r_stuck_level  <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!En) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt <= '0;
            // Start edge only: opens a measurement, reports nothing.
            if (w_rise) begin
              r_cnt   <= CNT_ONE;
              r_stuck <= 1'b0;
              r_state <= HIGH;
            end
          end
          HIGH: begin
            if (r_cnt == CNT_MAX) begin
              r_stuck       <= 1'b1;
              r_stuck_level <= w_s;
              r_overflow    <= 1'b1;
              r_cnt         <= '0;
              r_state       <= IDLE;
            end else if (w_fall) begin
              r_hi_lat <= r_cnt;
              r_cnt    <= r_cnt + CNT_ONE;
              r_state  <= LOW;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          LOW: begin
            if (r_cnt == CNT_MAX) begin
              r_stuck       <= 1'b1;
              r_stuck_level <= w_s;
              r_overflow    <= 1'b1;
              r_cnt         <= '0;
              r_state       <= IDLE;
            end else if (w_rise) begin
              r_period_count <= r_cnt;
              r_high_count   <= r_hi_lat;
              r_valid        <= 1'b1;
              r_stuck        <= 1'b0;
              r_cnt          <= CNT_ONE;
              r_state        <= HIGH;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign HighCount   = r_high_count;
  assign PeriodCount = r_period_count;
  assign Valid       = r_valid;
  assign Stuck       = r_stuck;
  assign StuckLevel  = r_stuck_level;
  assign Overflow    = r_overflow;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic        MClk;
  logic        rst16, rst8, En;
  logic        pwm16, pwm8;
  logic [15:0] hi16, per16;
  logic [7:0]  hi8, per8;
  logic        vld16, stuck16, slvl16, ovf16;
  logic        vld8, stuck8, slvl8, ovf8;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int wide16 = 0;
  logic v16_prev = 1'b0;

  int evc16[$], evh16[$], evp16[$], rise16[$];
  int evc8[$],  evh8[$],  evp8[$],  rise8[$];

  pwm_capture #(.BIT_WIDTH(16), .SYNC_STAGES(2), .FILT_LEN(4)) dut16 (
    .MClk(MClk), .Rst(rst16), .En(En), .PwmIn(pwm16),
    .HighCount(hi16), .PeriodCount(per16), .Valid(vld16),
    .Stuck(stuck16), .StuckLevel(slvl16), .Overflow(ovf16)
  );

  pwm_capture #(.BIT_WIDTH(8), .SYNC_STAGES(2), .FILT_LEN(4)) dut8 (
    .MClk(MClk), .Rst(rst8), .En(En), .PwmIn(pwm8),
    .HighCount(hi8), .PeriodCount(per8), .Valid(vld8),
    .Stuck(stuck8), .StuckLevel(slvl8), .Overflow(ovf8)
  );

  initial MClk = 1'b0;
  always #5 MClk = ~MClk;

  always @(posedge MClk) cyc <= cyc + 1;

  // Record every Valid pulse with its cycle number and reported values.
  always @(negedge MClk) begin
    if (vld16) begin
      evc16.push_back(cyc);
      evh16.push_back(int'(hi16));
      evp16.push_back(int'(per16));
    end
    if (vld8) begin
      evc8.push_back(cyc);
      evh8.push_back(int'(hi8));
      evp8.push_back(int'(per8));
    end
    if (vld16 && v16_prev) wide16 <= wide16 + 1;
    v16_prev <= vld16;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MClk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_pwm(input int sel, input logic v);
    if (sel == 0) begin
      if (v && !pwm16) rise16.push_back(cyc);
      pwm16 = v;
    end else begin
      if (v && !pwm8) rise8.push_back(cyc);
      pwm8 = v;
    end
  endtask

  task automatic drive(input int sel, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      set_pwm(sel, v);
      tick();
    end
  endtask

  task automatic run_period(input int sel, input int h, input int l);
    drive(sel, 1'b1, h);
    drive(sel, 1'b0, l);
  endtask

  task automatic run_pwm(input int sel, input int h, input int p, input int n);
    for (int i = 0; i < n; i++) run_period(sel, h, p - h);
  endtask

  task automatic clear_q();
    evc16.delete(); evh16.delete(); evp16.delete(); rise16.delete();
    evc8.delete();  evh8.delete();  evp8.delete();  rise8.delete();
  endtask

  task automatic do_reset16();
    rst16 = 1'b1;
    ticks(2);
    rst16 = 1'b0;
  endtask

  // Event k must carry hi/per and appear LAT edges after rise number ridx.
  task automatic check_ev(input string tag, input int sel, input int k, input int ridx,
                          input int hi, input int per);
    int sz;
    sz = (sel == 0) ? evc16.size() : evc8.size();
    if (k >= sz) begin
      check({tag, "_present"}, sz, k + 1);
    end else if (sel == 0) begin
      check({tag, "_hi"}, evh16[k], hi);
      check({tag, "_per"}, evp16[k], per);
      check({tag, "_lat"}, evc16[k], rise16[ridx] + LAT);
    end else begin
      check({tag, "_hi"}, evh8[k], hi);
      check({tag, "_per"}, evp8[k], per);
      check({tag, "_lat"}, evc8[k], rise8[ridx] + LAT);
    end
  endtask

  initial begin
    rst16 = 1'b1; rst8 = 1'b1; En = 1'b1; pwm16 = 1'b0; pwm8 = 1'b0;
    ticks(3);
    check("rst_hi16", hi16, 0);
    check("rst_per16", per16, 0);
    check("rst_vld16", vld16, 0);
    check("rst_stuck16", stuck16, 0);
    check("rst_ovf16", ovf16, 0);
    check("rst_ovf8", ovf8, 0);
    rst16 = 1'b0; rst8 = 1'b0;
    tick();

    // Test 1: steady 25/100 stream.
    clear_q();
    run_pwm(0, 25, 100, 5);
    ticks(5);
    check("t1_count", evc16.size(), 4);
    for (int k = 0; k < 4; k++) check_ev($sformatf("t1_ev%0d", k), 0, k, k + 1, 25, 100);
    check("t1_width", wide16, 0);

    // Test 4: En dropped mid-LOW for 50 cycles.
    do_reset16();
    clear_q();
    run_pwm(0, 25, 100, 2);
    drive(0, 1'b1, 25);
    drive(0, 1'b0, 25);
    En = 1'b0;
    drive(0, 1'b0, 50);
    check("t4_hold_hi", hi16, 25);
    check("t4_hold_per", per16, 100);
    check("t4_hold_vld", vld16, 0);
    check("t4_hold_count", evc16.size(), 2);
    En = 1'b1;
    drive(0, 1'b0, 25);
    run_pwm(0, 25, 100, 3);
    ticks(5);
    check("t4_count", evc16.size(), 4);
    check_ev("t4_ev0", 0, 0, 1, 25, 100);
    check_ev("t4_ev1", 0, 1, 2, 25, 100);
    check_ev("t4_ev2", 0, 2, 4, 25, 100);
    check_ev("t4_ev3", 0, 3, 5, 25, 100);

    // Test 2: switch mid-LOW to a 70/100 stream.
    do_reset16();
    clear_q();
    run_pwm(0, 25, 100, 2);
    run_period(0, 25, 25);
    run_pwm(0, 70, 100, 4);
    ticks(5);
    check("t2_count", evc16.size(), 6);
    check_ev("t2_ev0", 0, 0, 1, 25, 100);
    check_ev("t2_ev1", 0, 1, 2, 25, 100);
    check_ev("t2_ev2", 0, 2, 3, 25, 50);
    check_ev("t2_ev3", 0, 3, 4, 70, 100);
    check_ev("t2_ev4", 0, 4, 5, 70, 100);
    check_ev("t2_ev5", 0, 5, 6, 70, 100);

    // Test 3: 8-bit instance, input stuck high after one rise.
    clear_q();
    set_pwm(1, 1'b1);
    for (int t = 1; t <= LAT + 255; t++) begin
      tick();
      if (t == LAT + 254) check("t3_stuck_early", stuck8, 0);
    end
    check("t3_stuck", stuck8, 1);
    check("t3_stuck_lvl", slvl8, 1);
    check("t3_ovf", ovf8, 1);
    check("t3_no_valid", evc8.size(), 0);
    drive(1, 1'b0, 30);
    check("t3_stuck_hold", stuck8, 1);
    run_pwm(1, 10, 40, 3);
    ticks(5);
    check("t3_stuck_clr", stuck8, 0);
    check("t3_ovf_sticky", ovf8, 1);
    check("t3_count", evc8.size(), 2);
    check_ev("t3_ev0", 1, 0, 2, 10, 40);
    check_ev("t3_ev1", 1, 1, 3, 10, 40);

    // Test 5: asynchronous reset in the middle of HIGH.
    do_reset16();
    clear_q();
    run_pwm(0, 25, 100, 2);
    drive(0, 1'b1, 10);
    check("t5_pre_hi", hi16, 25);
    check("t5_pre_ovf8", ovf8, 1);
    #3;
    rst16 = 1'b1; rst8 = 1'b1;
    #1;
    check("t5_async_hi", hi16, 0);
    check("t5_async_per", per16, 0);
    check("t5_async_vld", vld16, 0);
    check("t5_async_stuck", stuck16, 0);
    check("t5_async_ovf8", ovf8, 0);
    check("t5_async_stuck8", stuck8, 0);
    check("t5_async_slvl8", slvl8, 0);
    check("t5_async_per8", per8, 0);
    tick();
    rst16 = 1'b0; rst8 = 1'b0;
    clear_q();
    drive(0, 1'b1, 15);
    drive(0, 1'b0, 85);
    run_pwm(0, 25, 100, 2);
    ticks(5);
    check("t5_count", evc16.size(), 2);
    check_ev("t5_ev0", 0, 0, 0, 15, 100);
    check_ev("t5_ev1", 0, 1, 1, 25, 100);

    // Test 6: 2-cycle high glitch inside the LOW phase.
    do_reset16();
    clear_q();
    run_pwm(0, 25, 100, 2);
    drive(0, 1'b1, 25);
    drive(0, 1'b0, 40);
    drive(0, 1'b1, 2);
    drive(0, 1'b0, 33);
    run_pwm(0, 25, 100, 2);
    ticks(5);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    check("t6_count", evc16.size(), 4);
    check_ev("t6_ev0", 0, 0, 1, 25, 100);
    check_ev("t6_ev1", 0, 1, 2, 25, 100);
    check_ev("t6_ev2", 0, 2, 4, 25, 100);
    check_ev("t6_ev3", 0, 3, 5, 25, 100);
`else
    check("t6_count", evc16.size(), 5);
    check_ev("t6_ev0", 0, 0, 1, 25, 100);
    check_ev("t6_ev1", 0, 1, 2, 25, 100);
    check_ev("t6_ev2", 0, 2, 3, 25, 65);
    check_ev("t6_ev3", 0, 3, 4, 2, 35);
    check_ev("t6_ev4", 0, 4, 5, 25, 100);
`endif
    check("final_width", wide16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
